// File: rtl/fpga_clock_reset_mc.sv
// Multi-channel clock/reset conditioner: each channel gates its region clock, moves its reset
// while the clock is stopped, then restarts the clock. Adds soft-reset pulses and a minimum reset.
module fpga_clock_reset_mc #(
    parameter int unsigned NbCh          = 4,
    parameter int unsigned CeMargin      = 5,
    parameter int unsigned HoldMargin    = 5,
    parameter int unsigned SetupMargin   = 5,
    parameter int unsigned MinRstCycles  = 16,
    parameter logic        RstPol        = 1'b0,
    parameter int unsigned RstSyncStages = 2
) (
    input  logic            clk_in_i,
    input  logic            rst_in_ni,
    input  logic [NbCh-1:0] rst_req_i,
    input  logic [NbCh-1:0] pulse_req_i,
    output logic [NbCh-1:0] clk_en_o,
    output logic [NbCh-1:0] rst_out_o,
    output logic [NbCh-1:0] busy_o
);

    localparam int unsigned MaxCh     = (CeMargin > HoldMargin) ? CeMargin : HoldMargin;
    localparam int unsigned MaxMargin = (MaxCh > SetupMargin) ? MaxCh : SetupMargin;
    localparam int unsigned CntW      = $clog2(MaxMargin + 1);
    localparam int unsigned MinW      = $clog2(MinRstCycles + 1);

    typedef enum logic [1:0] {StIdle, StGate, StHold, StSetup} state_e;

    // Assertion is asynchronous; release is delayed through the synchroniser chain.
    logic [RstSyncStages-1:0] sync_q;
    logic                     rst_int_n;

    always_ff @(posedge clk_in_i or negedge rst_in_ni) begin
        if (!rst_in_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[RstSyncStages-2:0], 1'b1};
        end
    end

    assign rst_int_n = sync_q[RstSyncStages-1];

    for (genvar g = 0; g < NbCh; g++) begin : g_ch
        state_e            state_q, state_d;
        logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
        logic [MinW-1:0]   min_q, min_d;
        logic              applied_q, applied_d;
        logic              tgt_q, tgt_d;
        logic              pend_q, pend_d;
        logic              clk_en_q;
        logic              target;
        logic              start;

        assign target  = rst_req_i[g] | pend_q | (min_q != '0);
        assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            tgt_d     = tgt_q;
            applied_d = applied_q;
            pend_d    = pend_q;
            min_d     = min_q;
            start     = 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (target != applied_q) begin
                        start   = 1'b1;
                        tgt_d   = target;
                        cnt_d   = '0;
                        state_d = StGate;
                    end
                end
                StGate: begin
                    if (cnt_q == CntW'(CeMargin - 1)) begin
                        cnt_d   = '0;
                        state_d = StHold;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StHold: begin
                    if (cnt_q == CntW'(HoldMargin - 1)) begin
                        cnt_d     = '0;
                        applied_d = tgt_q;
                        state_d   = StSetup;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StSetup: begin
                    if (cnt_q == CntW'(SetupMargin - 1)) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = StIdle;
            endcase

            // A pending pulse is honoured once an assert sequence starts or reset is already held.
            if (pulse_req_i[g]) begin
                pend_d = ~(start & target);
            end else if ((start & target) | ((state_q == StIdle) & applied_q)) begin
                pend_d = 1'b0;
            end

            if ((applied_d & ~applied_q) | (pulse_req_i[g] & applied_q)) begin
                min_d = MinW'(MinRstCycles);
            end else if (applied_q && (min_q != '0)) begin
                min_d = min_q - MinW'(1);
            end
        end

        always_ff @(posedge clk_in_i or negedge rst_int_n) begin
            if (!rst_int_n) begin
                state_q   <= StIdle;
                cnt_q     <= '0;
                applied_q <= 1'b1;
                tgt_q     <= 1'b1;
                pend_q    <= 1'b0;
                min_q     <= MinW'(MinRstCycles);
                clk_en_q  <= 1'b1;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                applied_q <= applied_d;
                tgt_q     <= tgt_d;
                pend_q    <= pend_d;
                min_q     <= min_d;
                clk_en_q  <= (state_d == StIdle);
            end
        end

        assign clk_en_o[g]  = clk_en_q;
        assign rst_out_o[g] = applied_q ? RstPol : ~RstPol;
        assign busy_o[g]    = (state_q != StIdle);
    end

endmodule

// File: tb/tb_fpga_clock_reset_mc.sv
// Directed bench for fpga_clock_reset_mc with default parameters (active-low rst_out).
module tb_fpga_clock_reset_mc;

    logic       clk;
    logic       rst_n;
    logic [3:0] rst_req;
    logic [3:0] pulse_req;
    logic [3:0] clk_en;
    logic [3:0] rst_out;
    logic [3:0] busy;

    int checks   = 0;
    int failures = 0;

    fpga_clock_reset_mc dut (
        .clk_in_i    (clk),
        .rst_in_ni   (rst_n),
        .rst_req_i   (rst_req),
        .pulse_req_i (pulse_req),
        .clk_en_o    (clk_en),
        .rst_out_o   (rst_out),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_rng(input int k, input int a, input int b);
        return (k >= a) && (k <= b);
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int k, input logic [3:0] ce,
                             input logic [3:0] rst);
        check($sformatf("%s_clk_en_c%0d", tag, k), clk_en, ce);
        check($sformatf("%s_rst_out_c%0d", tag, k), rst_out, rst);
        check($sformatf("%s_busy_c%0d", tag, k), busy, ~ce);
    endtask

    initial begin
        logic [3:0] ce_e;
        logic [3:0] rst_e;
        logic       b;

        rst_n     = 1'b0;
        rst_req   = 4'h0;
        pulse_req = 4'h0;
        repeat (3) tick();
        check_all("reset", 0, 4'hF, 4'h0);

        // Release: 2 sync cycles, 16 min cycles, then a deassert sequence on every channel.
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            ce_e  = in_rng(k, 19, 33) ? 4'h0 : 4'hF;
            rst_e = (k >= 29) ? 4'hF : 4'h0;
            check_all("release", k, ce_e, rst_e);
        end

        // Level request on channel 1 only.
        rst_req = 4'b0010;
        for (int k = 1; k <= 20; k++) begin
            tick();
            ce_e  = in_rng(k, 1, 15) ? 4'b1101 : 4'hF;
            rst_e = (k >= 11) ? 4'b1101 : 4'hF;
            check_all("req1", k, ce_e, rst_e);
        end

        // Single-cycle soft reset on channel 0.
        pulse_req = 4'b0001;
        for (int k = 1; k <= 46; k++) begin
            tick();
            if (k == 1) pulse_req = 4'h0;
            b     = ~(in_rng(k, 2, 16) | in_rng(k, 29, 43));
            ce_e  = {3'b111, b};
            b     = ~in_rng(k, 12, 38);
            rst_e = {3'b110, b};
            check_all("pulse0", k, ce_e, rst_e);
        end

        // Channel 2: assert, then pulse lands in the GATE phase of the following deassert.
        rst_req = 4'b0110;
        for (int k = 1; k <= 90; k++) begin
            tick();
            if (k == 1) rst_req = 4'b0010;
            if (k == 29) pulse_req = 4'b0100;
            if (k == 30) pulse_req = 4'h0;
            b     = ~(in_rng(k, 1, 15) | in_rng(k, 28, 42) | in_rng(k, 44, 58) |
                      in_rng(k, 71, 85));
            ce_e  = {1'b1, b, 2'b11};
            b     = ~(in_rng(k, 11, 37) | in_rng(k, 54, 80));
            rst_e = {1'b1, b, 2'b01};
            check_all("pulse2", k, ce_e, rst_e);
        end

        // Channel 3: request withdrawn during HOLD; assertion still completes.
        rst_req = 4'b1010;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 7) rst_req = 4'b0010;
            b     = ~(in_rng(k, 1, 15) | in_rng(k, 28, 42));
            ce_e  = {b, 3'b111};
            b     = ~in_rng(k, 11, 37);
            rst_e = {b, 3'b101};
            check_all("hold3", k, ce_e, rst_e);
        end

        // Channel 0 sequence interrupted by rst_in_n during SETUP.
        rst_req = 4'b0011;
        for (int k = 1; k <= 12; k++) begin
            tick();
            rst_e = (k >= 11) ? 4'b1100 : 4'b1101;
            check_all("setup0", k, 4'b1110, rst_e);
        end
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 4'hF, 4'h0);
        tick();
        check_all("async_rst", 1, 4'hF, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
